// File: rtl/crossbar_pkg.sv
// Shared types and constants for the crossbar arbiters.
package crossbar_pkg;

  localparam int unsigned N_DEFAULT = 32;
  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/crossbar_slave_arbiter_rr_picker.sv
// Round-robin picker: first set request at or above rr_ptr, searching upward with wrap.
module rr_picker #(
  parameter int unsigned MASTERS = 4,
  parameter int unsigned ID_W    = $clog2(MASTERS)
) (
  input  logic [MASTERS-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic               found,
  output logic [ID_W-1:0]    idx
);

  localparam int unsigned CW = ID_W + 1;

  logic [CW-1:0] cand;

  // Walk from the farthest offset down so the nearest hit is the one that sticks.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = int'(MASTERS) - 1; i >= 0; i--) begin
      cand = CW'(rr_ptr) + CW'(i);
      if (cand >= CW'(MASTERS)) begin
        cand = cand - CW'(MASTERS);
      end
      if (req[cand[ID_W-1:0]]) begin
        found = 1'b1;
        idx   = cand[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/crossbar_slave_arbiter.sv
// Round-robin arbiter sharing one crossbar slave among several masters, with a
// watchdog that terminates transactions the slave never acknowledges.
module crossbar_slave_arbiter
  import crossbar_pkg::*;
#(
  parameter int unsigned N       = N_DEFAULT,
  parameter int unsigned MASTERS = 4,
  parameter int unsigned ID_W    = $clog2(MASTERS),
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MASTERS-1:0]   master_req,
  input  logic [MASTERS*N-1:0] master_addr,
  input  logic [MASTERS-1:0]   master_cmd,
  input  logic [MASTERS*N-1:0] master_wdata,
  output logic [MASTERS-1:0]   master_ack,
  output logic [MASTERS*N-1:0] master_rdata,
  output logic                 slave_req,
  output logic [N-1:0]         slave_addr,
  output logic                 slave_cmd,
  output logic [N-1:0]         slave_wdata,
  input  logic                 slave_ack,
  input  logic [N-1:0]         slave_rdata,
  output logic                 busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 timeout_err,
  input  logic                 err_clr
);

  localparam int unsigned     CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t       state_q, state_d;
  logic [ID_W-1:0]  grant_d;
  logic [ID_W-1:0]  rr_q, rr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_d;
  logic             timeout_hit;
  logic             found;
  logic [ID_W-1:0]  pick_idx;

  rr_picker #(
    .MASTERS (MASTERS),
    .ID_W    (ID_W)
  ) u_picker (
    .req    (master_req),
    .rr_ptr (rr_q),
    .found  (found),
    .idx    (pick_idx)
  );

  assign busy = (state_q == BUSY);

  // Next state plus combinational routing between the granted master and the slave.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_id;
    rr_d         = rr_q;
    cnt_d        = cnt_q;
    err_d        = timeout_err;
    timeout_hit  = 1'b0;
    slave_req    = 1'b0;
    slave_addr   = '0;
    slave_cmd    = 1'b0;
    slave_wdata  = '0;
    master_ack   = '0;
    master_rdata = '0;

    if (err_clr) begin
      err_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          grant_d = pick_idx;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        timeout_hit = (TIMEOUT != 0) && (cnt_q == WD_LAST) && !slave_ack;
        slave_req   = master_req[grant_id] && !timeout_hit;
        slave_addr  = master_addr[int'(grant_id)*N +: N];
        slave_cmd   = master_cmd[grant_id];
        slave_wdata = master_wdata[int'(grant_id)*N +: N];
        master_ack[grant_id] = slave_ack || timeout_hit;
        master_rdata[int'(grant_id)*N +: N] = timeout_hit ? N'(ERR_RDATA) : slave_rdata;
        if (slave_ack || timeout_hit) begin
          state_d = IDLE;
          rr_d    = (grant_id == ID_W'(MASTERS - 1)) ? '0 : grant_id + ID_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        // A watchdog expiry outranks a simultaneous clear.
        if (timeout_hit) begin
          err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      grant_id    <= '0;
      rr_q        <= '0;
      cnt_q       <= '0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_id    <= grant_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      timeout_err <= err_d;
    end
  end

endmodule

// File: tb/tb_crossbar_slave_arbiter.sv
// Directed bench for crossbar_slave_arbiter with a completion scoreboard.
module tb_crossbar_slave_arbiter;

  localparam int unsigned N  = 32;
  localparam int unsigned M  = 4;
  localparam int unsigned IW = 2;

  typedef struct {
    int          id;
    logic [31:0] rd;
  } exp_t;

  logic           clk;
  logic           rst;
  logic [M-1:0]   m_req;
  logic [M*N-1:0] m_addr;
  logic [M-1:0]   m_cmd;
  logic [M*N-1:0] m_wdata;
  logic [M-1:0]   master_ack;
  logic [M*N-1:0] master_rdata;
  logic           slave_req;
  logic [N-1:0]   slave_addr;
  logic           slave_cmd;
  logic [N-1:0]   slave_wdata;
  logic           s_ack;
  logic [N-1:0]   s_rdata;
  logic           busy;
  logic [IW-1:0]  grant_id;
  logic           timeout_err;
  logic           err_clr;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  crossbar_slave_arbiter #(
    .N       (N),
    .MASTERS (M),
    .ID_W    (IW),
    .TIMEOUT (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .master_req   (m_req),
    .master_addr  (m_addr),
    .master_cmd   (m_cmd),
    .master_wdata (m_wdata),
    .master_ack   (master_ack),
    .master_rdata (master_rdata),
    .slave_req    (slave_req),
    .slave_addr   (slave_addr),
    .slave_cmd    (slave_cmd),
    .slave_wdata  (slave_wdata),
    .slave_ack    (s_ack),
    .slave_rdata  (s_rdata),
    .busy         (busy),
    .grant_id     (grant_id),
    .timeout_err  (timeout_err),
    .err_clr      (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every master_ack must match the oldest expected completion.
  always @(negedge clk) begin : monitor
    exp_t           e;
    logic [M*N-1:0] ev;
    logic [M-1:0]   ea;
    if (master_ack !== '0) begin
      if (sb.size() == 0) begin
        n_checks++;
        assert (master_ack === 4'b0000) else begin
          n_fail++;
          $error("FAIL unexpected_ack: observed %b expected 0000", master_ack);
        end
      end else begin
        e  = sb.pop_front();
        ev = '0;
        ev[e.id*N +: N] = e.rd;
        ea = M'(1) << e.id;
        n_checks++;
        assert (master_ack === ea) else begin
          n_fail++;
          $error("FAIL sb_ack: observed %b expected %b", master_ack, ea);
        end
        n_checks++;
        assert (master_rdata === ev) else begin
          n_fail++;
          $error("FAIL sb_rdata: observed %h expected %h", master_rdata, ev);
        end
      end
    end
  end

  // Entered just after a negedge in IDLE with requests already applied.
  task automatic run_txn(input int id, input logic [31:0] rd, input logic [M-1:0] nxt);
    @(posedge clk); #1;
    s_ack   = 1'b1;
    s_rdata = rd;
    sb.push_back('{id, rd});
    @(negedge clk);
    chk("txn_grant", 128'(grant_id), 128'(id));
    chk("txn_busy", 128'(busy), 1);
    chk("txn_sreq", 128'(slave_req), 1);
    chk("txn_addr", 128'(slave_addr), 128'(m_addr[id*N +: N]));
    chk("txn_cmd", 128'(slave_cmd), 128'(m_cmd[id]));
    chk("txn_wdata", 128'(slave_wdata), 128'(m_wdata[id*N +: N]));
    @(posedge clk); #1;
    s_ack = 1'b0;
    m_req = nxt;
    @(negedge clk);
    chk("txn_bubble", 128'(busy), 0);
  endtask

  initial begin
    rst     = 1'b0;
    m_req   = '0;
    m_addr  = '0;
    m_cmd   = '0;
    m_wdata = '0;
    s_ack   = 1'b0;
    s_rdata = '0;
    err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_busy", 128'(busy), 0);
    chk("rst_grant", 128'(grant_id), 0);
    chk("rst_err", 128'(timeout_err), 0);
    chk("rst_sreq", 128'(slave_req), 0);
    chk("rst_mack", 128'(master_ack), 0);
    chk("rst_mrdata", 128'(master_rdata), 0);

    // Master 1 read, slave acks in the third BUSY cycle.
    @(posedge clk); #1;
    m_addr[1*N +: N] = 32'h0000_0010;
    m_cmd[1]         = 1'b0;
    m_req            = 4'b0010;
    @(negedge clk);
    chk("t1_idle_sreq", 128'(slave_req), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_grant", 128'(grant_id), 1);
    chk("t1_busy", 128'(busy), 1);
    chk("t1_sreq_c1", 128'(slave_req), 1);
    chk("t1_addr", 128'(slave_addr), 32'h0000_0010);
    chk("t1_cmd", 128'(slave_cmd), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_sreq_c2", 128'(slave_req), 1);
    @(posedge clk); #1;
    s_ack   = 1'b1;
    s_rdata = 32'h1234_5678;
    sb.push_back('{1, 32'h1234_5678});
    @(negedge clk);
    chk("t1_sreq_c3", 128'(slave_req), 1);
    @(posedge clk); #1;
    s_ack = 1'b0;
    m_req = '0;
    @(negedge clk);
    chk("t1_done_busy", 128'(busy), 0);
    chk("t1_done_sreq", 128'(slave_req), 0);

    // Fresh reset, then all four masters request continuously.
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    for (int i = 0; i < int'(M); i++) begin
      m_addr[i*N +: N]  = 32'h1000_0000 + 32'(i) * 32'h100;
      m_wdata[i*N +: N] = 32'hC0DE_0000 + 32'(i);
    end
    m_cmd = 4'b1010;
    m_req = 4'hF;
    @(negedge clk);
    chk("t2_start_idle", 128'(busy), 0);
    for (int k = 0; k < 5; k++) begin
      run_txn(k % 4, 32'hA000_0000 + 32'(k), (k == 4) ? 4'h0 : 4'hF);
    end

    // Bring rr_ptr to 3, then masters 0 and 2 compete.
    @(posedge clk); #1 m_req = 4'b0100;
    @(negedge clk);
    run_txn(2, 32'hB000_0002, 4'b0101);
    run_txn(0, 32'hB000_0000, 4'b0101);
    run_txn(2, 32'hB000_0012, 4'b0000);

    // Watchdog expiry on master 3 with a silent slave.
    @(posedge clk); #1 m_req = 4'b1000;
    @(negedge clk);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 8) sb.push_back('{3, 32'hDEAD_BEEF});
      @(negedge clk);
      chk("t4_sreq", 128'(slave_req), (c == 8) ? 0 : 1);
      chk("t4_err_pre", 128'(timeout_err), 0);
    end
    @(posedge clk); #1 m_req = '0;
    @(negedge clk);
    chk("t4_idle", 128'(busy), 0);
    chk("t4_err_set", 128'(timeout_err), 1);
    chk("t4_last_grant", 128'(grant_id), 3);
    @(posedge clk); #1;
    s_ack   = 1'b1;
    s_rdata = 32'hBAD0_0001;
    @(negedge clk);
    chk("t4_stray_ack", 128'(master_ack), 0);
    chk("t4_stray_busy", 128'(busy), 0);
    @(posedge clk); #1;
    s_ack   = 1'b0;
    err_clr = 1'b1;
    @(negedge clk);
    chk("t4_err_hold", 128'(timeout_err), 1);
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    chk("t4_err_clr", 128'(timeout_err), 0);

    // Ack lands in the same cycle the watchdog would fire.
    @(posedge clk); #1 m_req = 4'b0010;
    @(negedge clk);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 8) begin
        s_ack   = 1'b1;
        s_rdata = 32'h5555_AAAA;
        sb.push_back('{1, 32'h5555_AAAA});
      end
      @(negedge clk);
      chk("t5_sreq", 128'(slave_req), 1);
    end
    @(posedge clk); #1;
    s_ack = 1'b0;
    m_req = '0;
    @(negedge clk);
    chk("t5_err", 128'(timeout_err), 0);
    chk("t5_idle", 128'(busy), 0);

    // Reset in the middle of a write by master 2.
    m_cmd[2] = 1'b1;
    @(posedge clk); #1 m_req = 4'b0110;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_grant", 128'(grant_id), 2);
    chk("t6_cmd", 128'(slave_cmd), 1);
    chk("t6_wdata", 128'(slave_wdata), 32'hC0DE_0002);
    #2 rst = 1'b0;
    #1;
    chk("t6_sreq", 128'(slave_req), 0);
    chk("t6_saddr", 128'(slave_addr), 0);
    chk("t6_scmd", 128'(slave_cmd), 0);
    chk("t6_swdata", 128'(slave_wdata), 0);
    chk("t6_mack", 128'(master_ack), 0);
    chk("t6_mrdata", 128'(master_rdata), 0);
    chk("t6_busy", 128'(busy), 0);
    chk("t6_gid", 128'(grant_id), 0);
    chk("t6_err", 128'(timeout_err), 0);
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    run_txn(1, 32'hC000_0001, 4'b0000);

    repeat (2) @(negedge clk);
    chk("sb_empty", 128'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
